// File: rtl/vc_ram_arb_pkg.sv
// Shared types for the two-requester RAM write-port arbiter.
package vc_ram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } state_e;

  // Index of one of the two write requesters; also the round-robin priority.
  typedef logic req_idx_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/vc_rr_arb2.sv
// Two-way round-robin picker: a lone valid wins, a tie goes to prio.
module vc_rr_arb2
  import vc_ram_arb_pkg::*;
(
  input  logic     [NUM_REQ-1:0] val,
  input  req_idx_t               prio,
  input  logic                   en,
  output logic     [NUM_REQ-1:0] grant,
  output req_idx_t               next_prio
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = en && val[gi] &&
                         (!val[NUM_REQ-1-gi] || (prio == req_idx_t'(gi)));
    end
  endgenerate

  // The winner yields priority to the other requester.
  always_comb begin
    next_prio = prio;
    if (grant[0]) begin
      next_prio = 1'b1;
    end else if (grant[1]) begin
      next_prio = 1'b0;
    end
  end

endmodule

// File: rtl/vc_ram_wport_arb.sv
// Arbitrates two write requesters onto the registered write port of a 1w1r RAM.
// Define VC_RAM_ARB_INIT_EN to sweep INIT_VALUE through every word after reset.
module vc_ram_wport_arb
  import vc_ram_arb_pkg::*;
#(
  parameter int                   DATA_SZ    = 1,
  parameter int                   ENTRIES    = 2,
  parameter int                   ADDR_SZ    = 1,
  parameter logic [DATA_SZ-1:0]   INIT_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0_val,
  output logic               req0_rdy,
  input  logic [ADDR_SZ-1:0] req0_addr,
  input  logic [DATA_SZ-1:0] req0_data,
  input  logic               req1_val,
  output logic               req1_rdy,
  input  logic [ADDR_SZ-1:0] req1_addr,
  input  logic [DATA_SZ-1:0] req1_data,
  input  logic               hold,
  output logic               ram_wen_p,
  output logic [ADDR_SZ-1:0] ram_waddr_p,
  output logic [DATA_SZ-1:0] ram_wdata_p,
  output logic               init_done,
  output logic               err_p
);

  localparam int               CNT_W     = ADDR_SZ + 1;
  localparam logic [CNT_W-1:0] ENTRIES_W = CNT_W'(ENTRIES);

  state_e               state_reg, state_next;
  req_idx_t             prio_reg, prio_next;
  logic                 wen_reg, wen_next;
  logic [ADDR_SZ-1:0]   waddr_reg, waddr_next;
  logic [DATA_SZ-1:0]   wdata_reg, wdata_next;
  logic                 err_reg, err_next;

  logic [NUM_REQ-1:0]   grant;
  req_idx_t             arb_next_prio;
  logic                 arb_en;
  logic                 accept;
  logic [ADDR_SZ-1:0]   sel_addr;
  logic [DATA_SZ-1:0]   sel_data;
  logic                 sel_in_range;

`ifdef VC_RAM_ARB_INIT_EN
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
`endif

  assign arb_en = (state_reg == ARB) && !hold;

  vc_rr_arb2 u_rr_arb2 (
    .val       ({req1_val, req0_val}),
    .prio      (prio_reg),
    .en        (arb_en),
    .grant     (grant),
    .next_prio (arb_next_prio)
  );

  assign req0_rdy     = grant[0];
  assign req1_rdy     = grant[1];
  assign accept       = |grant;
  assign sel_addr     = grant[1] ? req1_addr : req0_addr;
  assign sel_data     = grant[1] ? req1_data : req0_data;
  assign sel_in_range = {1'b0, sel_addr} < ENTRIES_W;

  always_comb begin
    state_next = state_reg;
    prio_next  = prio_reg;
    wen_next   = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    err_next   = 1'b0;
`ifdef VC_RAM_ARB_INIT_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      INIT: begin
`ifdef VC_RAM_ARB_INIT_EN
        // The counter runs one past the last word so ARB opens a cycle later.
        if (cnt_reg == ENTRIES_W) begin
          state_next = ARB;
        end else begin
          wen_next   = 1'b1;
          waddr_next = cnt_reg[ADDR_SZ-1:0];
          wdata_next = INIT_VALUE;
          cnt_next   = cnt_reg + CNT_W'(1);
        end
`else
        state_next = ARB;
`endif
      end
      ARB: begin
        prio_next = arb_next_prio;
        if (accept) begin
          if (sel_in_range) begin
            wen_next   = 1'b1;
            waddr_next = sel_addr;
            wdata_next = sel_data;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= INIT;
      prio_reg  <= 1'b0;
      wen_reg   <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
      wen_reg   <= wen_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      err_reg   <= err_next;
    end
  end

`ifdef VC_RAM_ARB_INIT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`endif

  assign ram_wen_p   = wen_reg;
  assign ram_waddr_p = waddr_reg;
  assign ram_wdata_p = wdata_reg;
  assign err_p       = err_reg;
  assign init_done   = (state_reg == ARB);

endmodule

// File: doc/vc_ram_wport_arb.md
VC_RAM_WPORT_ARB -- requirements
Module: vc_ram_wport_arb

Interface
REQ-001 SHALL have parameter DATA_SZ, default 1, width of write data.
REQ-002 SHALL have parameter ENTRIES, default 2, number of RAM words.
REQ-003 SHALL have parameter ADDR_SZ, default 1, address width; (1<<ADDR_SZ) >= ENTRIES.
REQ-004 SHALL have parameter INIT_VALUE, default 0, word written by the init sweep.
REQ-005 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports req0_val / req1_val, input, 1: write request valid.
REQ-008 SHALL have ports req0_rdy / req1_rdy, output, 1: request accepted this cycle.
REQ-009 SHALL have ports req0_addr / req1_addr, input, ADDR_SZ: write address.
REQ-010 SHALL have ports req0_data / req1_data, input, DATA_SZ: write data.
REQ-011 SHALL have port hold, input, 1: owner stall; blocks all grants.
REQ-012 SHALL have port ram_wen_p, output, 1: registered write enable to the 1w1r RAM.
REQ-013 SHALL have port ram_waddr_p, output, ADDR_SZ: registered write address.
REQ-014 SHALL have port ram_wdata_p, output, DATA_SZ: registered write data.
REQ-015 SHALL have port init_done, output, 1: high once the block is accepting requests.
REQ-016 SHALL have port err_p, output, 1: one-cycle pulse on an accepted out-of-range address.

Function
REQ-017 SHALL have two states: INIT and ARB; reset enters INIT.
REQ-018 In INIT, req0_rdy and req1_rdy SHALL be 0 regardless of val or hold.
REQ-019 In ARB, reqN_rdy SHALL be combinational: hold=0, reqN_val=1, and N wins arbitration.
REQ-020 Arbitration SHALL be round-robin on a 1-bit prio register: a lone valid requester wins; if both are valid, requester prio wins.
REQ-021 After a grant to requester i, prio SHALL become 1-i; with no grant, prio SHALL be unchanged.
REQ-022 An accept (val && rdy at a clk edge) SHALL drive ram_wen_p=1 with that requester's addr and data in the following cycle; the RAM write lands one edge later.
REQ-023 A cycle with no accept SHALL drive ram_wen_p=0 in the next cycle; ram_waddr_p and ram_wdata_p SHALL hold their last values.
REQ-024 An accepted request with addr >= ENTRIES SHALL be consumed with ram_wen_p=0 and err_p=1 in the next cycle.
REQ-025 At most one grant SHALL occur per cycle; back-to-back accepts SHALL sustain one RAM write per cycle.
REQ-026 Changing hold SHALL take effect on rdy in the same cycle; hold=1 SHALL leave prio unchanged.

Reset
REQ-027 While reset_n=0: ram_wen_p=0, ram_waddr_p=0, ram_wdata_p=0, init_done=0, err_p=0, prio=0, sweep counter=0, state=INIT.
REQ-028 Reset asserted mid-sweep or mid-operation SHALL abort immediately; the sweep SHALL restart at address 0 after release.

Configuration
REQ-029 Macro VC_RAM_ARB_INIT_EN SHALL control the init sweep.
REQ-030 With VC_RAM_ARB_INIT_EN defined: from the first edge after release, INIT SHALL drive ram_wen_p=1 with addresses 0..ENTRIES-1, one per cycle, data INIT_VALUE, ignoring hold; ARB and init_done=1 SHALL begin the cycle after address ENTRIES-1 is driven.
REQ-031 Without VC_RAM_ARB_INIT_EN: no sweep; the first edge after release SHALL enter ARB with init_done=1, and ram_wen_p SHALL stay 0 until the first accept.

Structure
REQ-032 Package vc_ram_arb_pkg SHALL hold the state enum (INIT, ARB) and the 1-bit requester-index typedef.
REQ-033 The 2-way round-robin picker SHALL be sub-module vc_rr_arb2 (inputs: val[1:0], prio, en; outputs: grant[1:0], next_prio).

Verification
REQ-034 INIT_EN, ENTRIES=4, INIT_VALUE=5: release reset -> ram_wen_p=1 at addrs 0,1,2,3 on consecutive cycles with data 5, then init_done=1; rdy=0 throughout.
REQ-035 Both valid every cycle, addrs 1/2 -> grants alternate 0,1,0,1 starting with req0; ram_waddr_p alternates 1,2 one cycle after each accept.
REQ-036 Only req1_val=1, data 0xA, addr 3 -> req1_rdy=1 each cycle; ram_wen_p=1, addr 3, data 0xA the next cycle; prio then favours req0.
REQ-037 ENTRIES=3, accept addr 3 -> next cycle ram_wen_p=0, err_p=1 for exactly one cycle.
REQ-038 hold=1 with both valid for 3 cycles -> rdy=0 and ram_wen_p=0; on hold=0, req0 is granted first (prio unchanged).
REQ-039 reset_n pulsed low at sweep address 2 -> outputs zero immediately; after release the sweep restarts at address 0.
